// File: rtl/frac_clk_pkg.sv
// Shared types and helpers for the fractional clock-enable monitor.
// Optional gap tracking is controlled by FRAC_CLK_MONITOR_GAP_EN (see frac_clk_monitor).
package frac_clk_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  // "No gap seen" markers; callers truncate to their own gap width.
  localparam logic [31:0] GAP_NONE_MIN = 32'hFFFF_FFFF;
  localparam logic [31:0] GAP_NONE_MAX = 32'd0;

  // Adds a single-bit increment, saturating at the all-ones value of a bits-wide field.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic inc,
                                          input int unsigned bits);
    logic [31:0] max;
    max = (bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
    return (inc && (a < max)) ? a + 32'd1 : a;
  endfunction

endpackage

// File: rtl/frac_clk_monitor_if.sv
// Control/result bundle between a measurement controller and frac_clk_monitor.
// Gap ports stay present whether or not FRAC_CLK_MONITOR_GAP_EN is defined.
interface frac_clk_monitor_if #(
  parameter int unsigned COUNTER_BITS = 16,
  parameter int unsigned GAP_BITS     = 8
);
  logic                    start;
  logic                    stop;
  logic                    en;
  logic [COUNTER_BITS-1:0] window_len;
  logic [COUNTER_BITS-1:0] expected;
  logic [COUNTER_BITS-1:0] tolerance;
  logic                    busy;
  logic                    valid;
  logic [COUNTER_BITS-1:0] count;
  logic                    mismatch;
  logic [GAP_BITS-1:0]     min_gap;
  logic [GAP_BITS-1:0]     max_gap;

  modport master (
    output start, stop, en, window_len, expected, tolerance,
    input  busy, valid, count, mismatch, min_gap, max_gap
  );

  modport slave (
    input  start, stop, en, window_len, expected, tolerance,
    output busy, valid, count, mismatch, min_gap, max_gap
  );
endinterface

// File: rtl/frac_clk_gap_tracker.sv
// Tracks spacing between consecutive en pulses and reports per-window min/max gaps.
// Only instantiated when FRAC_CLK_MONITOR_GAP_EN is defined.
module frac_clk_gap_tracker
  import frac_clk_pkg::*;
#(
  parameter int unsigned GAP_BITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                en,
  input  logic                window_end,
  output logic [GAP_BITS-1:0] min_gap,
  output logic [GAP_BITS-1:0] max_gap
);

  localparam logic [GAP_BITS-1:0] MinNone = GAP_BITS'(GAP_NONE_MIN);
  localparam logic [GAP_BITS-1:0] MaxNone = GAP_BITS'(GAP_NONE_MAX);

  logic                ref_valid_q, ref_valid_d;
  logic [GAP_BITS-1:0] gap_cnt_q, gap_cnt_d;
  logic [GAP_BITS-1:0] min_acc_q, min_acc_d, max_acc_q, max_acc_d;
  logic [GAP_BITS-1:0] min_gap_q, min_gap_d, max_gap_q, max_gap_d;
  logic [GAP_BITS-1:0] cur_min, cur_max;

  always_comb begin
    cur_min = min_acc_q;
    cur_max = max_acc_q;
    // gap_cnt_q holds cycles since the reference pulse, so it is the gap closed by this pulse
    if (en && ref_valid_q) begin
      if (gap_cnt_q < cur_min) cur_min = gap_cnt_q;
      if (gap_cnt_q > cur_max) cur_max = gap_cnt_q;
    end

    ref_valid_d = ref_valid_q | en;
    gap_cnt_d   = en ? GAP_BITS'(1) : GAP_BITS'(sat_add(32'(gap_cnt_q), 1'b1, GAP_BITS));
    min_acc_d   = cur_min;
    max_acc_d   = cur_max;
    min_gap_d   = min_gap_q;
    max_gap_d   = max_gap_q;

    if (clear) begin
      ref_valid_d = 1'b0;
      gap_cnt_d   = '0;
      min_acc_d   = MinNone;
      max_acc_d   = MaxNone;
    end else if (window_end) begin
      min_gap_d = cur_min;
      max_gap_d = cur_max;
      min_acc_d = MinNone;
      max_acc_d = MaxNone;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_valid_q <= 1'b0;
      gap_cnt_q   <= '0;
      min_acc_q   <= MinNone;
      max_acc_q   <= MaxNone;
      min_gap_q   <= MinNone;
      max_gap_q   <= MaxNone;
    end else begin
      ref_valid_q <= ref_valid_d;
      gap_cnt_q   <= gap_cnt_d;
      min_acc_q   <= min_acc_d;
      max_acc_q   <= max_acc_d;
      min_gap_q   <= min_gap_d;
      max_gap_q   <= max_gap_d;
    end
  end

  assign min_gap = min_gap_q;
  assign max_gap = max_gap_q;

endmodule

// File: rtl/frac_clk_monitor.sv
// Windowed rate checker for enable strobes: counts pulses per window and flags deviations.
// Define FRAC_CLK_MONITOR_GAP_EN to add min/max pulse-spacing measurement.
module frac_clk_monitor
  import frac_clk_pkg::*;
#(
  parameter int unsigned COUNTER_BITS = 16,
  parameter int unsigned GAP_BITS     = 8
) (
  input logic               clk,
  input logic               reset_n,
  frac_clk_monitor_if.slave mon
);

  state_e                  state_q, state_d;
  logic                    clear, latch, window_end;
  logic [COUNTER_BITS-1:0] wl_q, wl_d, exp_q, exp_d, tol_q, tol_d;
  logic [COUNTER_BITS-1:0] cyc_q, cyc_d, pcnt_q, pcnt_d, pcnt_inc;
  logic [COUNTER_BITS-1:0] count_q, count_d;
  logic [COUNTER_BITS:0]   diff;
  logic                    mis_calc, mismatch_q, mismatch_d, valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (mon.start && !mon.stop) state_d = StRun;
      StRun:   if (mon.stop) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Stop and restart both discard the partial window and take precedence over its end.
  always_comb begin
    clear      = 1'b1;
    latch      = 1'b1;
    window_end = 1'b0;
    if (state_q == StRun) begin
      clear      = mon.stop || mon.start;
      window_end = !clear && (cyc_q == wl_q - COUNTER_BITS'(1));
      latch      = mon.start || window_end;
    end
  end

  always_comb begin
    pcnt_inc = COUNTER_BITS'(sat_add(32'(pcnt_q), mon.en, COUNTER_BITS));
    if (pcnt_inc >= exp_q) diff = {1'b0, pcnt_inc} - {1'b0, exp_q};
    else                   diff = {1'b0, exp_q} - {1'b0, pcnt_inc};
    mis_calc = diff > {1'b0, tol_q};

    wl_d  = wl_q;
    exp_d = exp_q;
    tol_d = tol_q;
    if (latch) begin
      wl_d  = (mon.window_len == '0) ? COUNTER_BITS'(1) : mon.window_len;
      exp_d = mon.expected;
      tol_d = mon.tolerance;
    end

    if (clear || window_end) begin
      cyc_d  = '0;
      pcnt_d = '0;
    end else begin
      cyc_d  = cyc_q + COUNTER_BITS'(1);
      pcnt_d = pcnt_inc;
    end

    count_d    = window_end ? pcnt_inc : count_q;
    mismatch_d = window_end ? mis_calc : mismatch_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wl_q       <= COUNTER_BITS'(1);
      exp_q      <= '0;
      tol_q      <= '0;
      cyc_q      <= '0;
      pcnt_q     <= '0;
      count_q    <= '0;
      mismatch_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      wl_q       <= wl_d;
      exp_q      <= exp_d;
      tol_q      <= tol_d;
      cyc_q      <= cyc_d;
      pcnt_q     <= pcnt_d;
      count_q    <= count_d;
      mismatch_q <= mismatch_d;
      valid_q    <= window_end;
    end
  end

  assign mon.busy     = (state_q == StRun);
  assign mon.valid    = valid_q;
  assign mon.count    = count_q;
  assign mon.mismatch = mismatch_q;

`ifdef FRAC_CLK_MONITOR_GAP_EN
  frac_clk_gap_tracker #(
    .GAP_BITS (GAP_BITS)
  ) u_gap_tracker (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .en         (mon.en),
    .window_end (window_end),
    .min_gap    (mon.min_gap),
    .max_gap    (mon.max_gap)
  );
`else
  assign mon.min_gap = GAP_BITS'(GAP_NONE_MIN);
  assign mon.max_gap = GAP_BITS'(GAP_NONE_MAX);
`endif

endmodule

// File: tb/tb_frac_clk_monitor.sv
// Self-checking bench for frac_clk_monitor against a timestamp-based window model.
// Gap expectations follow FRAC_CLK_MONITOR_GAP_EN.
module tb_frac_clk_monitor;
  localparam int unsigned CB = 16;
  localparam int unsigned GB = 8;
`ifdef FRAC_CLK_MONITOR_GAP_EN
  localparam bit GapEn = 1'b1;
`else
  localparam bit GapEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  frac_clk_monitor_if #(.COUNTER_BITS(CB), .GAP_BITS(GB)) mon_if ();

  frac_clk_monitor #(
    .COUNTER_BITS (CB),
    .GAP_BITS     (GB)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mon     (mon_if)
  );

  int errors = 0;
  int checks = 0;

  // Model: absolute cycle stamps of pulses; window closes after W counted cycles.
  longint now = 0;
  longint m_last;
  bit     m_busy;
  int     m_w, m_exp, m_tol, m_pos, m_pulses;
  int     gaps[$];
  bit     e_valid, e_mis;
  int     e_count, e_min, e_max;

  function automatic logic [34:0] act_vec();
    return {mon_if.busy, mon_if.valid, mon_if.mismatch, mon_if.count, mon_if.min_gap,
            mon_if.max_gap};
  endfunction

  function automatic logic [34:0] exp_vec();
    return {m_busy, e_valid, e_mis, CB'(e_count), GB'(e_min), GB'(e_max)};
  endfunction

  task automatic model_reset();
    m_busy = 0; e_valid = 0; e_mis = 0; e_count = 0; e_min = 255; e_max = 0;
    m_pos = 0; m_pulses = 0; m_last = -1; gaps.delete();
  endtask

  task automatic model_latch();
    m_w   = (mon_if.window_len == 0) ? 1 : int'(mon_if.window_len);
    m_exp = int'(mon_if.expected);
    m_tol = int'(mon_if.tolerance);
  endtask

  task automatic model_restart();
    model_latch();
    m_pos = 0; m_pulses = 0; m_last = -1; gaps.delete();
  endtask

  task automatic model_step();
    int d;
    now++;
    e_valid = 0;
    if (!reset_n) begin
      model_reset();
    end else if (!m_busy) begin
      if (mon_if.start && !mon_if.stop) begin
        m_busy = 1;
        model_restart();
      end
    end else if (mon_if.stop) begin
      m_busy = 0;
    end else if (mon_if.start) begin
      model_restart();
    end else begin
      if (mon_if.en) begin
        m_pulses++;
        if (m_last >= 0) gaps.push_back((now - m_last > 255) ? 255 : int'(now - m_last));
        m_last = now;
      end
      m_pos++;
      if (m_pos == m_w) begin
        e_valid = 1;
        e_count = (m_pulses > 65535) ? 65535 : m_pulses;
        d = e_count - m_exp;
        if (d < 0) d = -d;
        e_mis = d > m_tol;
        e_min = 255; e_max = 0;
        if (GapEn) begin
          foreach (gaps[i]) begin
            if (gaps[i] < e_min) e_min = gaps[i];
            if (gaps[i] > e_max) e_max = gaps[i];
          end
        end
        model_latch();
        m_pos = 0; m_pulses = 0; gaps.delete();
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic setup(input int wl, input int ex, input int tol);
    mon_if.window_len = CB'(wl);
    mon_if.expected   = CB'(ex);
    mon_if.tolerance  = CB'(tol);
  endtask

  task automatic go_idle();
    mon_if.stop = 1; mon_if.start = 0; mon_if.en = 0;
    tick();
    mon_if.stop = 0;
  endtask

  task automatic test_reset();
    checks++;
    if (act_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_hold got=%h want=%h", act_vec(), exp_vec());
    end
    repeat (2) tick();
    reset_n = 1;
    repeat (3) begin
      tick();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_release cyc=%0d got=%h want=%h", now, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_periodic();
    go_idle();
    setup(16, 4, 0);
    mon_if.start = 1;
    tick();
    mon_if.start = 0;
    for (int k = 0; k < 70; k++) begin
      mon_if.en = (k % 4 == 1);
      tick();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL periodic cyc=%0d got=%h want=%h", now, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_irregular();
    int acc;
    go_idle();
    acc = 0;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) setup(24, 9, 0);
      else           setup(24, 11, 1);
      mon_if.start = 1;  // second pass restarts while running
      tick();
      mon_if.start = 0;
      for (int k = 0; k < 80; k++) begin
        acc += 3;
        mon_if.en = (acc >= 8);
        if (acc >= 8) acc -= 8;
        tick();
        checks++;
        if (act_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL irregular pass=%0d cyc=%0d got=%h want=%h", pass, now, act_vec(),
                   exp_vec());
        end
      end
    end
  endtask

  task automatic test_edges();
    go_idle();
    setup(0, 1, 0);
    mon_if.start = 1;
    tick();
    mon_if.start = 0;
    mon_if.en = 1;
    repeat (20) begin
      tick();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL en_high_w0 cyc=%0d got=%h want=%h", now, act_vec(), exp_vec());
      end
    end
    go_idle();
    setup(8, 0, 0);
    mon_if.start = 1;
    tick();
    mon_if.start = 0;
    repeat (26) begin
      tick();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL en_low_w8 cyc=%0d got=%h want=%h", now, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_stop();
    go_idle();
    setup(16, 3, 1);
    mon_if.start = 1;
    tick();
    mon_if.start = 0;
    for (int k = 0; k < 45; k++) begin
      mon_if.en   = (k % 5 == 2);
      mon_if.stop = (k == 28);  // three cycles before the second window closes
      tick();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL stop cyc=%0d got=%h want=%h", now, act_vec(), exp_vec());
      end
    end
    mon_if.stop = 0;
    mon_if.start = 1; mon_if.stop = 1;
    tick();
    mon_if.start = 0; mon_if.stop = 0;
    repeat (4) begin
      tick();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL start_stop_idle cyc=%0d got=%h want=%h", now, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    go_idle();
    setup(4, 2, 0);
    mon_if.start = 1;
    tick();
    mon_if.start = 0;
    for (int k = 0; k < 20; k++) begin
      mon_if.en    = (k % 2 == 0);
      mon_if.start = (k == 3);  // coincides with the first window end
      tick();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL restart_at_end cyc=%0d got=%h want=%h", now, act_vec(), exp_vec());
      end
    end
    mon_if.start = 0;
  endtask

  task automatic test_reset_mid();
    go_idle();
    setup(10, 5, 0);
    mon_if.start = 1;
    tick();
    mon_if.start = 0;
    mon_if.en = 1;
    repeat (14) tick();
    reset_n = 0;
    #1;
    model_reset();
    checks++;
    if (act_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_async got=%h want=%h", act_vec(), exp_vec());
    end
    repeat (2) tick();
    reset_n = 1;
    for (int k = 0; k < 30; k++) begin
      mon_if.start = (k == 15);
      tick();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_recover cyc=%0d got=%h want=%h", now, act_vec(), exp_vec());
      end
    end
    mon_if.start = 0;
  endtask

  task automatic test_gap_sat();
    go_idle();
    setup(1000, 4, 0);
    mon_if.start = 1;
    tick();
    mon_if.start = 0;
    for (int k = 0; k < 2010; k++) begin
      mon_if.en = (k % 300 == 10);
      tick();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL gap_sat cyc=%0d got=%h want=%h", now, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    go_idle();
    for (int k = 0; k < 600; k++) begin
      setup($urandom_range(0, 9), $urandom_range(0, 6), $urandom_range(0, 2));
      mon_if.en    = ($urandom_range(0, 2) == 0);
      mon_if.start = ($urandom_range(0, 39) == 0) || (k == 0);
      mon_if.stop  = ($urandom_range(0, 59) == 0);
      tick();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h want=%h", now, act_vec(), exp_vec());
      end
    end
    mon_if.start = 0; mon_if.stop = 0; mon_if.en = 0;
  endtask

  initial begin
    reset_n = 0;
    mon_if.start = 0; mon_if.stop = 0; mon_if.en = 0;
    setup(1, 0, 0);
    model_reset();
    m_w = 1; m_exp = 0; m_tol = 0;
    #2;
    test_reset();
    test_periodic();
    test_irregular();
    test_edges();
    test_stop();
    test_back_to_back();
    test_reset_mid();
    test_gap_sat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
